axi4_mem_port_arbiter: RTL and testbench
========================================

Name: axi4_mem_port_arbiter

Overview:
- Burst-granular arbiter for the AXI4 memory-mapped slave.
- Shares the single-port backing memory between the write-burst engine (AW/W/B side) and the read-burst engine (AR/R side).
- Grants whole bursts of AxLEN+1 beats, alternates fairly when both sides contend, and inserts a programmable bus-turnaround gap between bursts.
- Sits between the two channel engines and the memory mux select.

Parameters:
- TURN_CYCLES, 1: idle cycles inserted after every burst before the next grant (0..15).
- LEN_WIDTH, 8: burst length field width; matches AWLEN/ARLEN.

Ports:
- ACLK  input  1  clock, rising edge.
- ARESETn  input  1  asynchronous active-low reset.
- wr_req  input  1  write engine has an accepted AW burst pending.
- wr_len  input  LEN_WIDTH  AWLEN of the pending write burst; beats = wr_len+1.
- wr_beat  input  1  write engine performs one memory write this cycle.
- rd_req  input  1  read engine has an accepted AR burst pending.
- rd_len  input  LEN_WIDTH  ARLEN of the pending read burst.
- rd_beat  input  1  read engine performs one memory read this cycle.
- err_clr  input  1  clears protocol_err.
- wr_gnt  output  1  memory owned by the write engine.
- rd_gnt  output  1  memory owned by the read engine.
- mem_sel  output  1  memory mux select: 0 = write path, 1 = read path; holds the last owner when idle.
- beats_left  output  LEN_WIDTH  beats remaining after the current one in the active burst.
- last_beat  output  1  high when the granted side's beat this cycle is the final beat.
- protocol_err  output  1  sticky flag: beat without grant, or beat in a non-burst state.

Behaviour:
- Reset (ARESETn low, asynchronous):
  - state=IDLE; wr_gnt=0; rd_gnt=0; mem_sel=0; beats_left=0; protocol_err=0.
  - Priority pointer favours write.
  - Turnaround counter is 0.
  - Reset mid-burst aborts the burst immediately; no grant survives.
- States: IDLE, WR_BURST, RD_BURST, TURN.
- IDLE:
  - Only wr_req: next state WR_BURST; beats_left<=wr_len; mem_sel<=0.
  - Only rd_req: next state RD_BURST; beats_left<=rd_len; mem_sel<=1.
  - Both: grant the side the pointer favours. Pointer then flips to favour the other side.
  - Grant latency: request sampled at edge N, gnt high from edge N+1.
- Lengths are latched only on the IDLE->BURST transition. Later changes to wr_len/rd_len are ignored.
- WR_BURST (wr_gnt=1), on wr_beat:
  - beats_left==0: burst ends. Next state is TURN if TURN_CYCLES>0, else IDLE. wr_gnt drops at the next edge.
  - Otherwise: beats_left decrements by 1.
  - No wr_beat: hold state; no timeout.
- RD_BURST: same as WR_BURST, using rd_beat and rd_gnt.
- last_beat is combinational: (wr_gnt&wr_beat | rd_gnt&rd_beat) & (beats_left==0).
- Dropping a request during a burst does not release the grant. The grant is held until the final beat.
- A single-grant side that completes while the other side is still requesting does not block that side: the pointer still favours the other side on the next tie.
- TURN:
  - Counter loads TURN_CYCLES-1 on entry and decrements each cycle.
  - Exit to IDLE when the counter reaches 0.
  - Both gnts are 0 throughout.
  - With TURN_CYCLES=1: final beat at edge M, TURN during M+1, IDLE at M+2, next gnt at M+3.
- protocol_err is set at the next edge by any of:
  - wr_beat while !wr_gnt
  - rd_beat while !rd_gnt
  - wr_beat and rd_beat in the same cycle
  The offending beat is ignored: no decrement and no state change. A legal beat in the same cycle is still counted.
- protocol_err clears on err_clr. If set and clear occur in the same cycle, set wins.
- wr_gnt and rd_gnt are never both 1 (one-hot or zero). Both are registered outputs.
- beats_left wraps never: decrement only when non-zero. A beat at 0 ends the burst.

Test Plan:
- Reset release, wr_req=1, wr_len=3 → wr_gnt at next edge, beats_left=3; four wr_beat pulses → beats_left 2,1,0, last_beat on the 4th, wr_gnt low the edge after, one TURN cycle.
- wr_req and rd_req both held, len=0 each, TURN_CYCLES=1 → grants alternate W,R,W,R; each gnt lasts exactly until its single beat; 2 idle cycles between grants.
- rd_req only, rd_len=255 with continuous rd_beat → rd_gnt high for 256 beat cycles, last_beat only on beat 256, mem_sel=1 throughout and after.
- During WR_BURST (beats_left=2), pulse rd_beat → protocol_err=1 next edge, beats_left unchanged; err_clr → protocol_err=0.
- Assert ARESETn low mid-RD_BURST with beats_left=5 → rd_gnt=0, beats_left=0, mem_sel=0 immediately, without waiting for a clock edge; after release with wr_req+rd_req → write granted first.
- TURN_CYCLES=0 variant: back-to-back write bursts → final beat at M, IDLE at M+1, wr_gnt again at M+2.

Source files
------------

// File: rtl/axi4_mem_port_arbiter.sv
// Burst-granular arbiter sharing a single-port memory between the AXI4
// write-burst engine and read-burst engine. Whole bursts are granted,
// ties alternate between the two sides, and a programmable turnaround
// gap separates consecutive bursts.
module axi4_mem_port_arbiter #(
    parameter int TURN_CYCLES = 1,
    parameter int LEN_WIDTH   = 8
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic                 wr_req,
    input  logic [LEN_WIDTH-1:0] wr_len,
    input  logic                 wr_beat,
    input  logic                 rd_req,
    input  logic [LEN_WIDTH-1:0] rd_len,
    input  logic                 rd_beat,
    input  logic                 err_clr,
    output logic                 wr_gnt,
    output logic                 rd_gnt,
    output logic                 mem_sel,
    output logic [LEN_WIDTH-1:0] beats_left,
    output logic                 last_beat,
    output logic                 protocol_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2,
        TURN     = 2'd3
    } state_t;

    // Turnaround counter reload value; unused when no gap is configured.
    localparam int          TURN_LOAD_I = (TURN_CYCLES > 0) ? (TURN_CYCLES - 1) : 0;
    localparam logic [3:0]  TURN_LOAD   = 4'(TURN_LOAD_I);
    // Where a finished burst goes: straight back to IDLE when the gap is zero.
    localparam state_t      END_STATE   = (TURN_CYCLES > 0) ? TURN : IDLE;

    state_t               state;
    state_t               state_next;
    logic                 prio_rd;        // 1 = read side wins the next tie
    logic                 prio_rd_next;
    logic [3:0]           turn_cnt;
    logic [3:0]           turn_cnt_next;
    logic [LEN_WIDTH-1:0] beats_next;
    logic                 sel_next;
    logic                 err_next;
    logic                 wr_ok;
    logic                 rd_ok;
    logic                 err_set;

    // A beat only counts when its side owns the memory; anything else is a
    // protocol violation and is otherwise ignored.
    assign wr_ok     = wr_gnt & wr_beat;
    assign rd_ok     = rd_gnt & rd_beat;
    assign err_set   = (wr_beat & ~wr_gnt) | (rd_beat & ~rd_gnt) | (wr_beat & rd_beat);
    assign last_beat = (wr_ok | rd_ok) & (beats_left == '0);

    // Next-state, burst length bookkeeping, tie-break pointer and error flag.
    always_comb begin
        state_next    = state;
        prio_rd_next  = prio_rd;
        turn_cnt_next = turn_cnt;
        beats_next    = beats_left;
        sel_next      = mem_sel;
        err_next      = err_set | (protocol_err & ~err_clr);

        case (state)
            IDLE: begin
                if (wr_req && (!rd_req || !prio_rd)) begin
                    state_next   = WR_BURST;
                    beats_next   = wr_len;
                    sel_next     = 1'b0;
                    prio_rd_next = 1'b1;
                end else if (rd_req) begin
                    state_next   = RD_BURST;
                    beats_next   = rd_len;
                    sel_next     = 1'b1;
                    prio_rd_next = 1'b0;
                end
            end
            WR_BURST: begin
                if (wr_ok) begin
                    if (beats_left == '0) begin
                        state_next    = END_STATE;
                        turn_cnt_next = TURN_LOAD;
                    end else begin
                        beats_next = beats_left - 1'b1;
                    end
                end
            end
            RD_BURST: begin
                if (rd_ok) begin
                    if (beats_left == '0) begin
                        state_next    = END_STATE;
                        turn_cnt_next = TURN_LOAD;
                    end else begin
                        beats_next = beats_left - 1'b1;
                    end
                end
            end
            TURN: begin
                if (turn_cnt == 4'd0) begin
                    state_next = IDLE;
                end else begin
                    turn_cnt_next = turn_cnt - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any burst in flight at once.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state        <= IDLE;
            prio_rd      <= 1'b0;
            turn_cnt     <= 4'd0;
            beats_left   <= '0;
            mem_sel      <= 1'b0;
            wr_gnt       <= 1'b0;
            rd_gnt       <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            state        <= state_next;
            prio_rd      <= prio_rd_next;
            turn_cnt     <= turn_cnt_next;
            beats_left   <= beats_next;
            mem_sel      <= sel_next;
            wr_gnt       <= (state_next == WR_BURST);
            rd_gnt       <= (state_next == RD_BURST);
            protocol_err <= err_next;
        end
    end

endmodule

// File: tb/tb_axi4_mem_port_arbiter.sv
// Directed bench for axi4_mem_port_arbiter: one instance with a one-cycle
// turnaround gap and one with no gap.
module tb_axi4_mem_port_arbiter;

    logic       ACLK;
    logic       ARESETn;
    logic       wr_req, wr_beat, rd_req, rd_beat, err_clr;
    logic [7:0] wr_len, rd_len;
    logic       wr_gnt, rd_gnt, mem_sel, last_beat, protocol_err;
    logic [7:0] beats_left;

    logic       z_wr_req, z_wr_beat, z_rd_req, z_rd_beat, z_err_clr;
    logic [7:0] z_wr_len, z_rd_len;
    logic       z_wr_gnt, z_rd_gnt, z_mem_sel, z_last_beat, z_protocol_err;
    logic [7:0] z_beats_left;

    int checks = 0;
    int errors = 0;

    axi4_mem_port_arbiter #(.TURN_CYCLES(1), .LEN_WIDTH(8)) u_dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .wr_req(wr_req), .wr_len(wr_len), .wr_beat(wr_beat),
        .rd_req(rd_req), .rd_len(rd_len), .rd_beat(rd_beat),
        .err_clr(err_clr),
        .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .mem_sel(mem_sel),
        .beats_left(beats_left), .last_beat(last_beat), .protocol_err(protocol_err)
    );

    axi4_mem_port_arbiter #(.TURN_CYCLES(0), .LEN_WIDTH(8)) u_dut0 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .wr_req(z_wr_req), .wr_len(z_wr_len), .wr_beat(z_wr_beat),
        .rd_req(z_rd_req), .rd_len(z_rd_len), .rd_beat(z_rd_beat),
        .err_clr(z_err_clr),
        .wr_gnt(z_wr_gnt), .rd_gnt(z_rd_gnt), .mem_sel(z_mem_sel),
        .beats_left(z_beats_left), .last_beat(z_last_beat), .protocol_err(z_protocol_err)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        ARESETn = 1'b0;
        wr_req = 0; wr_beat = 0; rd_req = 0; rd_beat = 0; err_clr = 0;
        wr_len = 0; rd_len = 0;
        z_wr_req = 0; z_wr_beat = 0; z_rd_req = 0; z_rd_beat = 0; z_err_clr = 0;
        z_wr_len = 0; z_rd_len = 0;

        // Reset state
        #2;
        chk("rst_wr_gnt", 32'(wr_gnt), 0);
        chk("rst_rd_gnt", 32'(rd_gnt), 0);
        chk("rst_mem_sel", 32'(mem_sel), 0);
        chk("rst_beats_left", 32'(beats_left), 0);
        chk("rst_protocol_err", 32'(protocol_err), 0);
        chk("rst_last_beat", 32'(last_beat), 0);
        tick();
        ARESETn = 1'b1;
        tick();

        // Single write burst of 4 beats followed by one turnaround cycle
        wr_req = 1; wr_len = 8'd3;
        tick();
        chk("t1_wr_gnt", 32'(wr_gnt), 1);
        chk("t1_rd_gnt", 32'(rd_gnt), 0);
        chk("t1_beats_left", 32'(beats_left), 3);
        chk("t1_mem_sel", 32'(mem_sel), 0);
        wr_req = 0; wr_len = 8'd9;
        wr_beat = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_last_beat", 32'(last_beat), (i == 3) ? 1 : 0);
            tick();
            if (i < 3) begin
                chk("t1_beats_dec", 32'(beats_left), 32'(2 - i));
                chk("t1_gnt_held", 32'(wr_gnt), 1);
            end
        end
        wr_beat = 0;
        chk("t1_gnt_drop", 32'(wr_gnt), 0);
        chk("t1_beats_end", 32'(beats_left), 0);
        wr_req = 1; wr_len = 8'd0;
        tick();
        chk("t1_turn_no_gnt", 32'(wr_gnt), 0);
        tick();
        chk("t1_regrant", 32'(wr_gnt), 1);
        wr_req = 0;
        wr_beat = 1;
        #1;
        chk("t1_len0_last", 32'(last_beat), 1);
        tick();
        wr_beat = 0;
        chk("t1_len0_drop", 32'(wr_gnt), 0);
        tick();
        tick();

        // Long read burst of 256 beats; length change mid-burst is ignored
        rd_req = 1; rd_len = 8'd255;
        tick();
        chk("t3_rd_gnt", 32'(rd_gnt), 1);
        chk("t3_mem_sel", 32'(mem_sel), 1);
        chk("t3_beats_left", 32'(beats_left), 255);
        rd_req = 0; rd_len = 8'd7;
        rd_beat = 1;
        for (int i = 0; i < 256; i++) begin
            #1;
            chk("t3_last_beat", 32'(last_beat), (i == 255) ? 1 : 0);
            chk("t3_beats", 32'(beats_left), 32'(255 - i));
            chk("t3_rd_gnt_hold", 32'(rd_gnt), 1);
            tick();
        end
        rd_beat = 0;
        chk("t3_rd_gnt_drop", 32'(rd_gnt), 0);
        chk("t3_mem_sel_hold", 32'(mem_sel), 1);
        tick();
        tick();
        chk("t3_mem_sel_idle", 32'(mem_sel), 1);
        chk("t3_no_err", 32'(protocol_err), 0);

        // Protocol errors during a write burst
        wr_req = 1; wr_len = 8'd2;
        tick();
        wr_req = 0;
        chk("t4_wr_gnt", 32'(wr_gnt), 1);
        chk("t4_beats", 32'(beats_left), 2);
        rd_beat = 1;
        tick();
        chk("t4_err_set", 32'(protocol_err), 1);
        chk("t4_beats_hold", 32'(beats_left), 2);
        chk("t4_gnt_hold", 32'(wr_gnt), 1);
        err_clr = 1;
        tick();
        chk("t4_set_wins", 32'(protocol_err), 1);
        rd_beat = 0;
        tick();
        chk("t4_err_clr", 32'(protocol_err), 0);
        err_clr = 0;
        wr_beat = 1; rd_beat = 1;
        tick();
        chk("t4_both_err", 32'(protocol_err), 1);
        chk("t4_legal_counted", 32'(beats_left), 1);
        wr_beat = 0; rd_beat = 0; err_clr = 1;
        tick();
        chk("t4_err_clr2", 32'(protocol_err), 0);
        err_clr = 0;
        wr_beat = 1;
        tick();
        chk("t4_beats0", 32'(beats_left), 0);
        #1;
        chk("t4_last", 32'(last_beat), 1);
        tick();
        wr_beat = 0;
        chk("t4_done", 32'(wr_gnt), 0);
        tick();
        tick();
        wr_beat = 1;
        tick();
        wr_beat = 0;
        chk("t4_idle_beat_err", 32'(protocol_err), 1);
        chk("t4_idle_no_gnt", 32'(wr_gnt), 0);
        err_clr = 1;
        tick();
        err_clr = 0;
        chk("t4_idle_clr", 32'(protocol_err), 0);

        // Asynchronous reset in the middle of a read burst
        rd_req = 1; rd_len = 8'd9;
        tick();
        rd_req = 0;
        rd_beat = 1;
        repeat (4) tick();
        rd_beat = 0;
        chk("t5_pre_beats", 32'(beats_left), 5);
        chk("t5_pre_gnt", 32'(rd_gnt), 1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("t5_async_gnt", 32'(rd_gnt), 0);
        chk("t5_async_beats", 32'(beats_left), 0);
        chk("t5_async_sel", 32'(mem_sel), 0);
        wr_req = 1; rd_req = 1; wr_len = 8'd0; rd_len = 8'd0;
        tick();
        chk("t5_in_rst_gnt", 32'(wr_gnt | rd_gnt), 0);
        #2;
        ARESETn = 1'b1;
        tick();

        // Alternation W,R,W,R with two idle cycles between grants
        for (int k = 0; k < 4; k++) begin
            chk("t2_wr_gnt", 32'(wr_gnt), (k % 2 == 0) ? 1 : 0);
            chk("t2_rd_gnt", 32'(rd_gnt), (k % 2 == 1) ? 1 : 0);
            chk("t2_mem_sel", 32'(mem_sel), 32'(k % 2));
            if (k % 2 == 0) wr_beat = 1; else rd_beat = 1;
            #1;
            chk("t2_last", 32'(last_beat), 1);
            tick();
            wr_beat = 0; rd_beat = 0;
            if (k == 3) begin
                wr_req = 0; rd_req = 0;
            end
            chk("t2_gap1", 32'(wr_gnt | rd_gnt), 0);
            tick();
            chk("t2_gap2", 32'(wr_gnt | rd_gnt), 0);
            tick();
        end
        chk("t2_idle_end", 32'(wr_gnt | rd_gnt), 0);
        chk("t2_sel_end", 32'(mem_sel), 1);
        chk("t2_no_err", 32'(protocol_err), 0);

        // Zero-cycle turnaround: back-to-back write bursts
        z_wr_req = 1; z_wr_len = 8'd1;
        tick();
        chk("t6_gnt", 32'(z_wr_gnt), 1);
        chk("t6_beats", 32'(z_beats_left), 1);
        z_wr_beat = 1;
        tick();
        chk("t6_beats0", 32'(z_beats_left), 0);
        #1;
        chk("t6_last", 32'(z_last_beat), 1);
        tick();
        z_wr_beat = 0;
        chk("t6_idle", 32'(z_wr_gnt), 0);
        tick();
        chk("t6_regrant", 32'(z_wr_gnt), 1);
        chk("t6_rebeats", 32'(z_beats_left), 1);
        z_wr_req = 0;
        z_wr_beat = 1;
        tick();
        tick();
        z_wr_beat = 0;
        chk("t6_end", 32'(z_wr_gnt), 0);
        chk("t6_no_err", 32'(z_protocol_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
